// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the two-port memory arbiter
package mem_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic        req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ,
    RESP
  } mem_arb_state_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - winner select, fixed priority or round-robin (MEM_ARB_RR_EN)
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_id_t            grant_id_o
);

`ifdef MEM_ARB_RR_EN
  // Reset value 0 means port 0 was "last", so port 1 wins the first contention.
  req_id_t last_grant_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_grant_q <= 1'b0;
    end else if (accept_i) begin
      last_grant_q <= grant_id_o;
    end
  end

  always_comb begin
    grant_id_o = valid_i[1];
    if (valid_i == 2'b11) begin
      grant_id_o = ~last_grant_q;
    end
  end
`else
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk_i, rstn_i, accept_i};

  always_comb begin
    grant_id_o = valid_i[1];
  end
`endif

  assign grant_o = (valid_i == '0) ? '0 : id_to_onehot(grant_id_o);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single memory_map port between fetch and load/store
// Optional round-robin arbitration via MEM_ARB_RR_EN (default fixed priority, port 1 first).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter addr_t IDLE_ADDR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][31:0]  req_wdata,
  input  logic [NUM_REQ-1:0][3:0]   req_wstrb,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic [31:0]               mem_address,
  output logic [31:0]               mem_write_data,
  output logic [3:0]                mem_write_enable,
  input  logic [31:0]               mem_read_data
);

  mem_arb_state_t     state_q;
  req_id_t            owner_q;
  logic [3:0]         wstrb_q;
  addr_t              mem_address_q;
  data_t              mem_wdata_q;
  logic [3:0]         mem_we_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  data_t              rsp_rdata_q;

  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_id;
  logic               accept;

  mem_arb_grant u_grant (
    .clk_i      (clk),
    .rstn_i     (reset),
    .valid_i    (req_valid),
    .accept_i   (accept),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  // A request in the same cycle as reset must not be granted.
  assign req_ready = (state_q == IDLE && reset) ? grant : '0;
  assign accept    = |req_ready;

  // Memory-side outputs are loaded on the accept edge so they are valid
  // for the whole ACCESS cycle and then held through READ.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      wstrb_q       <= '0;
      mem_address_q <= IDLE_ADDR;
      mem_wdata_q   <= '0;
      mem_we_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q       <= grant_id;
            wstrb_q       <= req_wstrb[grant_id];
            mem_address_q <= req_addr[grant_id];
            mem_wdata_q   <= req_wdata[grant_id];
            mem_we_q      <= req_wstrb[grant_id];
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q <= '0;
          if (wstrb_q != '0) begin
            rsp_valid_q <= id_to_onehot(owner_q);
            state_q     <= RESP;
          end else begin
            state_q <= READ;
          end
        end
        READ: begin
          rsp_rdata_q <= mem_read_data;
          rsp_valid_q <= id_to_onehot(owner_q);
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam addr_t LED_ADDR = 32'h1000_0000;
  localparam addr_t IDLE_A   = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0][3:0]   req_wstrb;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [31:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_enable;
  logic [31:0]       mem_read_data;

  mem_arbiter #(.IDLE_ADDR(IDLE_A)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_wstrb        (req_wstrb),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  // memory_map stand-in: registered RAM read, combinational LEDR read
  data_t ram [16];
  data_t ledr;
  data_t ram_rd_q;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_write_enable[b] === 1'b1) begin
        if (mem_address == LED_ADDR) ledr[b*8 +: 8] <= mem_write_data[b*8 +: 8];
        else ram[mem_address[5:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
      end
    end
    ram_rd_q <= ram[mem_address[5:2]];
  end
  assign mem_read_data = (mem_address == LED_ADDR) ? ledr : ram_rd_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic data_t merge(input data_t old, input data_t wd, input logic [3:0] s);
    data_t r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic int winner(input logic [1:0] v, input bit lg);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef MEM_ARB_RR_EN
    return lg ? 0 : 1;
`else
    return (lg === 1'b0 || lg === 1'b1) ? 1 : 1;
`endif
  endfunction

  // transaction-level reference model
  bit     rst_at_edge = 1'b0;
  int     cyc = 0;
  bit     busy = 1'b0;
  int     acc_cyc;
  bit     m_wr;
  int     m_own;
  addr_t  m_addr;
  data_t  m_wdata, m_exp;
  logic [3:0] m_strb;
  bit     last_g = 1'b0;
  addr_t  cur_addr = IDLE_A;
  data_t  sh_ram [16];
  data_t  sh_led;

  int     obs_acc_cyc, obs_rsp_cyc, obs_rsp_port;
  data_t  obs_rdata [2];
  int     we_cycles = 0;
  int     rsp_count = 0;
  int     glog [$];

  always @(posedge clk) rst_at_edge = reset;

  always @(negedge clk) begin
    int         exp_lat;
    logic [1:0] exp_rsp;
    logic [3:0] exp_we;
    logic [1:0] exp_rdy;
    int         w;
    bit         idle_now;
    cyc++;
    if (mem_write_enable != 4'h0) we_cycles++;
    if (req_ready != 2'b00) obs_acc_cyc = cyc;
    if (rsp_valid != 2'b00) begin
      rsp_count++;
      obs_rsp_cyc  = cyc;
      obs_rsp_port = int'(rsp_valid[1]);
      obs_rdata[rsp_valid[1]] = rsp_rdata;
    end
    if (!rst_at_edge) begin
      chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_addr", mem_address, IDLE_A);
      chk("rst_mem_wdata", mem_write_data, 32'h0);
      chk("rst_mem_we", {28'b0, mem_write_enable}, 32'h0);
      busy     = 1'b0;
      last_g   = 1'b0;
      cur_addr = IDLE_A;
      idle_now = 1'b1;
    end else begin
      idle_now = !busy;
      exp_lat  = m_wr ? 2 : 3;
      exp_rsp  = 2'b00;
      exp_we   = 4'h0;
      if (busy && cyc == acc_cyc + exp_lat) exp_rsp[m_own] = 1'b1;
      if (busy && m_wr && cyc == acc_cyc + 1) exp_we = m_strb;
      chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, exp_rsp});
      chk("mem_we", {28'b0, mem_write_enable}, {28'b0, exp_we});
      if (exp_we != 4'h0) chk("mem_wdata", mem_write_data, m_wdata);
      chk("mem_addr", mem_address, cur_addr);
      if (exp_rsp != 2'b00 && !m_wr) chk("rsp_rdata", rsp_rdata, m_exp);
      if (exp_rsp != 2'b00) busy = 1'b0;
    end
    exp_rdy = 2'b00;
    w = -1;
    if (idle_now && reset) w = winner(req_valid, last_g);
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", {30'b0, req_ready}, {30'b0, exp_rdy});
    if (w >= 0) begin
      busy     = 1'b1;
      acc_cyc  = cyc;
      m_own    = w;
      m_addr   = req_addr[w];
      m_wdata  = req_wdata[w];
      m_strb   = req_wstrb[w];
      m_wr     = (m_strb != 4'h0);
      cur_addr = m_addr;
      last_g   = w[0];
      glog.push_back(w);
      if (m_wr) begin
        if (m_addr == LED_ADDR) sh_led = merge(sh_led, m_wdata, m_strb);
        else sh_ram[m_addr[5:2]] = merge(sh_ram[m_addr[5:2]], m_wdata, m_strb);
      end else begin
        m_exp = (m_addr == LED_ADDR) ? sh_led : sh_ram[m_addr[5:2]];
      end
    end
  end

  task automatic do_txn(input int p, input addr_t a, input data_t wd, input logic [3:0] s);
    bit got;
    @(posedge clk); #1;
    req_valid    = 2'b00;
    req_valid[p] = 1'b1;
    req_addr[p]  = a;
    req_wdata[p] = wd;
    req_wstrb[p] = s;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) got = 1'b1;
    end
    if (!got) chk("grant_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (5) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int w0, r0;
  bit got;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]    = 32'hA000_0000 + i;
      sh_ram[i] = 32'hA000_0000 + i;
    end
    ram[0] = 32'h1234_5678; sh_ram[0] = 32'h1234_5678;
    ram[4] = 32'hDEAD_BEEF; sh_ram[4] = 32'hDEAD_BEEF;
    ledr = 32'h0; sh_led = 32'h0;
    ram_rd_q = 32'h0;
    reset = 1'b0;
    req_valid = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // directed read, port 1
    do_txn(1, 32'h0000_0010, 32'h0, 4'h0);
    chk("rd_latency", obs_rsp_cyc - obs_acc_cyc, 3);
    chk("rd_port", obs_rsp_port, 1);
    chk("rd_data", obs_rdata[1], 32'hDEAD_BEEF);

    // directed LEDR write then read-back
    w0 = we_cycles;
    do_txn(1, LED_ADDR, 32'h0000_02A5, 4'hF);
    chk("wr_latency", obs_rsp_cyc - obs_acc_cyc, 2);
    chk("wr_we_pulses", we_cycles - w0, 1);
    do_txn(1, LED_ADDR, 32'h0, 4'h0);
    chk("rb_data", obs_rdata[1], 32'h0000_02A5);

    // both ports valid continuously from a fresh reset
    pulse_reset();
    glog.delete();
    @(posedge clk); #1;
    req_addr[0] = 32'h0; req_addr[1] = 32'h10;
    req_wstrb[0] = 4'h0; req_wstrb[1] = 4'h0;
    req_valid = 2'b11;
    repeat (16) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);
    chk("contend_count", (glog.size() >= 4) ? 1 : 0, 1);
    foreach (glog[i]) begin
`ifdef MEM_ARB_RR_EN
      chk("rr_grant", glog[i], (i % 2 == 0) ? 1 : 0);
`else
      chk("fp_grant", glog[i], 1);
`endif
    end
`ifdef MEM_ARB_RR_EN
    chk("p0_data", obs_rdata[0], 32'h1234_5678);
`endif

    // reset during READ of a pending read
    r0 = rsp_count;
    @(posedge clk); #1;
    req_addr[1] = 32'h10; req_wstrb[1] = 4'h0; req_valid = 2'b10;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
    end
    if (!got) chk("grant_timeout", 32'h0, 32'h1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_read_addr", mem_address, IDLE_A);
    repeat (6) @(posedge clk);
    chk("rst_no_rsp", rsp_count - r0, 0);

    // idle window
    w0 = we_cycles;
    repeat (10) @(posedge clk);
    chk("idle_we", we_cycles - w0, 0);

    // randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 499) != 0);
      for (int p = 0; p < 2; p++) begin
        int r, k;
        req_valid[p] = $urandom_range(0, 1);
        r = $urandom_range(0, 16);
        req_addr[p]  = (r == 16) ? LED_ADDR : 32'(r * 4);
        req_wdata[p] = $urandom;
        k = $urandom_range(0, 3);
        req_wstrb[p] = (k == 1) ? 4'hF : (k == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port memory_map (RAM + LEDR register) on the de1-soc target.
- Shares the one memory port between instruction fetch (port 0) and load/store (port 1).
- Owns all timing of the memory port: holds address stable across the registered-read cycle, issues writes as single-cycle strobes, and returns a one-cycle response pulse to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters; fixed at 2 in this revision.
- IDLE_ADDR, 32'h0000_0000, address driven on mem_address after reset until the first grant.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  [1:0]  per-port request valid
- req_ready  out  [1:0]  per-port grant/accept
- req_addr  in  2 x addr_t  per-port byte address
- req_wdata  in  2 x data_t  per-port write data
- req_wstrb  in  2 x [3:0]  per-port byte write enables; all zero means read
- rsp_valid  out  [1:0]  one-cycle response pulse to the owning port
- rsp_rdata  out  data_t  read data, valid while rsp_valid is set (shared by both ports)
- mem_address  out  addr_t  to memory_map address
- mem_write_data  out  data_t  to memory_map write_data
- mem_write_enable  out  [3:0]  to memory_map write_enable
- mem_read_data  in  data_t  from memory_map read_data

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0.
  - mem_address=IDLE_ADDR; mem_write_data=0; mem_write_enable=0.
  - Any in-flight transaction is dropped with no response and no write.
- FSM states: IDLE, ACCESS, READ, RESP.
- IDLE:
  - req_ready is combinational: exactly one bit is set, for the winner among the valid ports; none if no port is valid.
  - On the accept edge, latch addr, wdata, wstrb and owner. Next state is ACCESS.
- ACCESS (accept cycle + 1):
  - Drive mem_address with the latched address.
  - For a write, mem_write_enable = latched wstrb for this cycle only, and mem_write_data = latched wdata. Next state is RESP.
  - For a read, mem_write_enable=0. Next state is READ.
- READ:
  - Hold mem_address unchanged. This is required because the LEDR read path decodes the address combinationally and the RAM read is registered.
  - Capture mem_read_data into rsp_rdata at the end of the cycle. Next state is RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle. No backpressure; the requester must accept.
  - For writes, rsp_rdata is unchanged. Next state is IDLE.
- Latency from accept edge to rsp_valid: read = 3 cycles, write = 2 cycles.
- Throughput: at most one transaction per 3 (write) or 4 (read) cycles. req_ready is 0 in every non-IDLE state.
- Outside ACCESS, mem_write_enable is always 0. mem_address holds its last driven value between transactions; it never toggles while idle.
- Arbitration (default, fixed priority): port 1 (data) wins over port 0 (fetch) when both are valid.
- A requester that deasserts req_valid before it is granted is simply not served; req_valid is not required to be sticky.
- Address and data pass through unmodified. Word/byte decoding stays in memory_map.
- Sub-word writes are forwarded with their strobe as given; memory_map handling of partial strobes is outside this block.
- Simultaneous reset and request: reset wins; no grant.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset value 0, meaning port 1 is preferred first) flips to the granted port on each accept. On contention, the port not granted last wins.
- Undefined: fixed priority (port 1 > port 0); no last_grant register.
- Latency and FSM are identical in both builds.

Decomposition:
- Add to the shared types header:
  - state enum mem_arb_state_t {IDLE, ACCESS, READ, RESP}
  - typedef req_id_t (1 bit)
- Keep addr_t and data_t from the existing header.
- One natural sub-module: mem_arb_grant, the combinational winner select with optional RR state, kept inside the MEM_ARB_RR_EN guard.
- FSM and latches stay in mem_arbiter.

Test Plan:
- Read on port 1, addr 0x0000_0010, RAM word 4 = 0xDEADBEEF:
  - req_ready[1] in cycle 0.
  - mem_address=0x10 held in cycles 1-2.
  - rsp_valid[1] with rsp_rdata=0xDEADBEEF in cycle 3.
- Write on port 1, addr 0x1000_0000, wdata 0x2A5, wstrb 4'hF:
  - mem_write_enable=4'hF for exactly cycle 1.
  - rsp_valid[1] in cycle 2.
  - A subsequent read of the same address returns 0x0000_02A5.
- Both ports valid continuously, fixed priority: port 1 is granted on every accept and port 0 is never granted.
- Same stimulus with MEM_ARB_RR_EN: grants alternate 1,0,1,0.
  - Each rsp_valid goes to the correct port.
  - Port 0 reads of addr 0x0 return RAM word 0.
- reset low during READ of a pending read:
  - Next cycle all outputs are at reset values.
  - No rsp_valid is emitted.
  - mem_address=IDLE_ADDR.
- Idle with no requests for 10 cycles: mem_write_enable stays 0, mem_address is stable, and req_ready=0.
